// File: rtl/spi_arbiter.sv
// Two-requester SPI byte-engine arbiter: round-robin grant,
// chip-select setup/release gaps and owner hold timeout.
module spi_arbiter #(
    parameter int SETUP   = 2,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] sel,
    input  logic [1:0] start,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    output logic [1:0] gnt,
    output logic       rdy,
    output logic [1:0] done,
    output logic [7:0] rx,
    output logic       tout,
    output logic       eng_start,
    output logic [7:0] eng_tx,
    input  logic       eng_done,
    input  logic [7:0] eng_rx,
    output logic [1:0] nss
);

    localparam logic [7:0] C_SETUP = 8'(SETUP);
    localparam logic [7:0] C_GAP   = 8'(GAP);
    localparam logic [7:0] C_TO    = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_READY,
        S_BUSY,
        S_RELEASE
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic       r_last;
    logic       r_own;
    logic [1:0] r_req;
    logic       r_done_in;
    logic [7:0] r_rx_in;
    logic [1:0] r_gnt;
    logic       r_rdy;
    logic [1:0] r_done;
    logic [7:0] r_rx;
    logic       r_tout;
    logic       r_eng_start;
    logic [7:0] r_eng_tx;
    logic [1:0] r_nss;

    logic [7:0] w_cnt_inc;
    logic       w_pick;
    logic       w_own_req;
    logic       w_own_start;
    logic       w_to_hit;
    logic       w_grant;
    logic       w_launch;
    logic       w_finish;
    logic       w_release;
    logic       w_to_ready;
    logic [7:0] w_cnt;
    logic       w_own;
    logic       w_last;
    logic [1:0] w_gnt;
    logic       w_rdy;
    logic [1:0] w_done;
    logic [7:0] w_rx;
    logic       w_tout;
    logic       w_eng_start;
    logic [7:0] w_eng_tx;
    logic [1:0] w_nss;

    assign w_cnt_inc   = r_cnt + 8'd1;
    assign w_own_req   = req[r_own];
    assign w_own_start = start[r_own];
    // On a tie the requester that did not hold the bus last wins
    assign w_pick      = (r_req == 2'b11) ? ~r_last : r_req[1];
    assign w_to_hit    = (TIMEOUT != 0) && (w_cnt_inc == C_TO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_last      <= 1'b1;
            r_own       <= 1'b0;
            r_req       <= 2'b00;
            r_done_in   <= 1'b0;
            r_rx_in     <= 8'd0;
            r_gnt       <= 2'b00;
            r_rdy       <= 1'b0;
            r_done      <= 2'b00;
            r_rx        <= 8'd0;
            r_tout      <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_tx    <= 8'd0;
            r_nss       <= 2'b11;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt;
            r_last      <= w_last;
            r_own       <= w_own;
            r_req       <= req;
            r_done_in   <= eng_done && (r_state == S_BUSY);
            r_rx_in     <= eng_rx;
            r_gnt       <= w_gnt;
            r_rdy       <= w_rdy;
            r_done      <= w_done;
            r_rx        <= w_rx;
            r_tout      <= w_tout;
            r_eng_start <= w_eng_start;
            r_eng_tx    <= w_eng_tx;
            r_nss       <= w_nss;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:
                if (|r_req) w_state_nxt = S_SETUP;
            S_SETUP:
                if (w_cnt_inc == C_SETUP) w_state_nxt = S_READY;
            S_READY:
                if (!w_own_req)       w_state_nxt = S_RELEASE;
                else if (w_own_start) w_state_nxt = S_BUSY;
                else if (w_to_hit)    w_state_nxt = S_RELEASE;
            S_BUSY:
                if (r_done_in)
                    w_state_nxt = w_own_req ? S_READY : S_RELEASE;
            S_RELEASE:
                if (w_cnt_inc == C_GAP) w_state_nxt = S_IDLE;
            default:
                w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant     = (r_state == S_IDLE) && (w_state_nxt == S_SETUP);
        w_launch    = (r_state == S_READY) && (w_state_nxt == S_BUSY);
        w_finish    = (r_state == S_BUSY) && (w_state_nxt != S_BUSY);
        w_release   = (r_state != S_RELEASE) && (w_state_nxt == S_RELEASE);
        w_to_ready  = (r_state != S_READY) && (w_state_nxt == S_READY);
        w_own       = r_own;
        w_last      = r_last;
        w_gnt       = r_gnt;
        w_rdy       = r_rdy;
        w_done      = 2'b00;
        w_rx        = r_rx;
        w_tout      = 1'b0;
        w_eng_start = 1'b0;
        w_eng_tx    = r_eng_tx;
        w_nss       = r_nss;
        if (w_grant) begin
            w_own  = w_pick;
            w_last = w_pick;
            w_gnt  = w_pick ? 2'b10 : 2'b01;
            w_nss  = sel[w_pick] ? 2'b01 : 2'b10;
        end
        if (w_to_ready) w_rdy = 1'b1;
        if (w_launch) begin
            w_eng_start = 1'b1;
            w_eng_tx    = r_own ? tx1 : tx0;
            w_rdy       = 1'b0;
        end
        if (w_finish) begin
            w_done = r_own ? 2'b10 : 2'b01;
            w_rx   = r_rx_in;
        end
        // Leaving READY with the request still up can only be a timeout
        if (w_release) begin
            w_gnt  = 2'b00;
            w_nss  = 2'b11;
            w_rdy  = 1'b0;
            w_tout = (r_state == S_READY) && w_own_req;
        end
        if (w_state_nxt != r_state)
            w_cnt = 8'd0;
        else if (r_state == S_SETUP || r_state == S_RELEASE)
            w_cnt = w_cnt_inc;
        else if (r_state == S_READY && TIMEOUT != 0)
            w_cnt = w_cnt_inc;
        else
            w_cnt = r_cnt;
    end

    assign gnt       = r_gnt;
    assign rdy       = r_rdy;
    assign done      = r_done;
    assign rx        = r_rx;
    assign tout      = r_tout;
    assign eng_start = r_eng_start;
    assign eng_tx    = r_eng_tx;
    assign nss       = r_nss;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: cycle model of the arbitration rules
// plus directed literal expectations for each scenario.
module tb_spi_arbiter;

    localparam int SETUP   = 2;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] sel = 2'b00;
    logic [1:0] start = 2'b00;
    logic [7:0] tx0 = 8'd0;
    logic [7:0] tx1 = 8'd0;
    logic       eng_done = 1'b0;
    logic [7:0] eng_rx = 8'd0;
    logic [1:0] gnt;
    logic       rdy;
    logic [1:0] done;
    logic [7:0] rx;
    logic       tout;
    logic       eng_start;
    logic [7:0] eng_tx;
    logic [1:0] nss;

    spi_arbiter #(
        .SETUP(SETUP),
        .GAP(GAP),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .sel(sel),
        .start(start),
        .tx0(tx0),
        .tx1(tx1),
        .gnt(gnt),
        .rdy(rdy),
        .done(done),
        .rx(rx),
        .tout(tout),
        .eng_start(eng_start),
        .eng_tx(eng_tx),
        .eng_done(eng_done),
        .eng_rx(eng_rx),
        .nss(nss)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    int         m_own;
    int         m_setup;
    int         m_idle;
    int         m_gap;
    bit         m_busy;
    bit         m_done_seen;
    bit         m_last;
    logic [1:0] m_req_seen;
    logic [7:0] m_rx_seen;
    logic [1:0] e_gnt;
    logic [1:0] e_nss;
    logic       e_rdy;
    logic [1:0] e_done;
    logic [7:0] e_rx;
    logic       e_tout;
    logic       e_start;
    logic [7:0] e_tx;

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1;
        m_setup = 0;
        m_idle = 0;
        m_gap = 0;
        m_busy = 1'b0;
        m_done_seen = 1'b0;
        m_last = 1'b1;
        m_req_seen = 2'b00;
        m_rx_seen = 8'd0;
        e_gnt = 2'b00;
        e_nss = 2'b11;
        e_rdy = 1'b0;
        e_done = 2'b00;
        e_rx = 8'd0;
        e_tout = 1'b0;
        e_start = 1'b0;
        e_tx = 8'd0;
    endtask

    task automatic release_bus();
        m_own = -1;
        m_gap = GAP;
        e_nss = 2'b11;
        e_gnt = 2'b00;
        e_rdy = 1'b0;
    endtask

    task automatic model_step();
        bit         was_busy;
        logic [1:0] rq;
        if (!rst_n) begin
            model_reset();
            return;
        end
        was_busy = m_busy;
        rq = m_req_seen;
        e_done = 2'b00;
        e_tout = 1'b0;
        e_start = 1'b0;
        if (m_own < 0) begin
            if (m_gap > 0) begin
                m_gap--;
            end else if (rq != 2'b00) begin
                if (rq == 2'b11) m_own = m_last ? 0 : 1;
                else m_own = rq[1] ? 1 : 0;
                m_last = (m_own == 1);
                e_gnt = (m_own == 1) ? 2'b10 : 2'b01;
                e_nss = sel[m_own] ? 2'b01 : 2'b10;
                m_setup = SETUP;
            end
        end else if (m_setup > 0) begin
            m_setup--;
            if (m_setup == 0) begin
                e_rdy = 1'b1;
                m_idle = 0;
            end
        end else if (!m_busy) begin
            if (!req[m_own]) begin
                release_bus();
            end else if (start[m_own]) begin
                e_start = 1'b1;
                e_tx = (m_own == 1) ? tx1 : tx0;
                e_rdy = 1'b0;
                m_busy = 1'b1;
            end else begin
                m_idle++;
                if (TIMEOUT != 0 && m_idle == TIMEOUT) begin
                    e_tout = 1'b1;
                    release_bus();
                end
            end
        end else if (m_done_seen) begin
            e_done = (m_own == 1) ? 2'b10 : 2'b01;
            e_rx = m_rx_seen;
            m_busy = 1'b0;
            if (req[m_own]) begin
                e_rdy = 1'b1;
                m_idle = 0;
            end else begin
                release_bus();
            end
        end
        m_req_seen = req;
        m_done_seen = eng_done && was_busy;
        m_rx_seen = eng_rx;
    endtask

    task automatic compare();
        chk("gnt", 8'(gnt), 8'(e_gnt));
        chk("nss", 8'(nss), 8'(e_nss));
        chk("rdy", 8'(rdy), 8'(e_rdy));
        chk("done", 8'(done), 8'(e_done));
        chk("rx", rx, e_rx);
        chk("tout", 8'(tout), 8'(e_tout));
        chk("eng_start", 8'(eng_start), 8'(e_start));
        chk("eng_tx", eng_tx, e_tx);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == 2'b00 && n < 40) begin
            tick();
            if (gnt == 2'b00) n++;
        end
        if (gnt == 2'b00) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_gnt cyc=%0d got=timeout exp=grant", cyc);
        end
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (rdy !== 1'b1) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_rdy cyc=%0d got=timeout exp=rdy", cyc);
        end
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) tick();
        chk("rst_gnt", 8'(gnt), 8'h0);
        chk("rst_nss", 8'(nss), 8'h3);
        chk("rst_rdy", 8'(rdy), 8'h0);
        rst_n = 1'b1;
        tick();

        sel = 2'b01;
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            int eo;
            eo = i % 2;
            wait_gnt(n);
            if (i > 0) chk("rr_nss_high", 8'(n + 1), 8'd3);
            chk("rr_gnt", 8'(gnt), (eo == 1) ? 8'h2 : 8'h1);
            chk("rr_nss_sel", 8'(nss), (eo == 1) ? 8'h2 : 8'h1);
            wait_rdy();
            start[eo] = 1'b1;
            if (eo == 1) tx1 = 8'(8'h10 + i);
            else tx0 = 8'(8'h10 + i);
            tick();
            chk("rr_eng_start", 8'(eng_start), 8'h1);
            chk("rr_eng_tx", eng_tx, 8'(8'h10 + i));
            start = 2'b00;
            req[eo] = 1'b0;
            tick();
            tick();
            eng_done = 1'b1;
            eng_rx = 8'(8'h50 + i);
            tick();
            eng_done = 1'b0;
            tick();
            chk("rr_done", 8'(done), (eo == 1) ? 8'h2 : 8'h1);
            chk("rr_rx", rx, 8'(8'h50 + i));
            chk("rr_release_nss", 8'(nss), 8'h3);
            if (i < 2) req[eo] = 1'b1;
        end

        wait_gnt(n);
        chk("to_owner", 8'(gnt), 8'h2);
        req = 2'b11;
        wait_rdy();
        n = 0;
        while (tout !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("to_delay", 8'(n), 8'd4);
        chk("to_nss", 8'(nss), 8'h3);
        chk("to_gnt", 8'(gnt), 8'h0);
        wait_gnt(n);
        chk("to_next_gnt", 8'(gnt), 8'h1);

        wait_rdy();
        start = 2'b10;
        tx1 = 8'hFF;
        tick();
        chk("nonowner_start", 8'(eng_start), 8'h0);
        chk("nonowner_rdy", 8'(rdy), 8'h1);
        start = 2'b01;
        tx0 = 8'h11;
        req = 2'b10;
        tick();
        chk("drop_start", 8'(eng_start), 8'h0);
        chk("drop_nss", 8'(nss), 8'h3);
        start = 2'b00;

        wait_gnt(n);
        chk("g1_gnt", 8'(gnt), 8'h2);
        chk("g1_nss", 8'(nss), 8'h2);
        wait_rdy();
        start = 2'b10;
        tx1 = 8'hC3;
        tick();
        chk("busy_start", 8'(eng_start), 8'h1);
        chk("busy_tx", eng_tx, 8'hC3);
        start = 2'b00;
        req = 2'b00;
        tick();
        tick();
        eng_done = 1'b1;
        eng_rx = 8'h99;
        tick();
        eng_done = 1'b0;
        eng_rx = 8'h00;
        tick();
        chk("busy_done", 8'(done), 8'h2);
        chk("busy_rx", rx, 8'h99);
        chk("busy_rel_nss", 8'(nss), 8'h3);
        chk("busy_rel_gnt", 8'(gnt), 8'h0);
        n = 0;
        repeat (6) begin
            tick();
            if (eng_start) n++;
        end
        chk("no_second_start", 8'(n), 8'd0);

        eng_done = 1'b1;
        eng_rx = 8'h77;
        tick();
        eng_done = 1'b0;
        tick();
        chk("spur_done", 8'(done), 8'h0);
        tick();
        chk("spur_done2", 8'(done), 8'h0);
        chk("spur_rx", rx, 8'h99);

        sel = 2'b01;
        req = 2'b01;
        tick();
        chk("lat_gnt_early", 8'(gnt), 8'h0);
        tick();
        chk("lat_gnt", 8'(gnt), 8'h1);
        chk("lat_nss", 8'(nss), 8'h1);
        chk("lat_rdy0", 8'(rdy), 8'h0);
        tick();
        chk("lat_rdy1", 8'(rdy), 8'h0);
        tick();
        chk("lat_rdy2", 8'(rdy), 8'h1);
        start = 2'b01;
        tx0 = 8'hA5;
        tick();
        chk("so_start", 8'(eng_start), 8'h1);
        chk("so_tx", eng_tx, 8'hA5);
        start = 2'b00;
        tick();
        chk("so_start_pulse", 8'(eng_start), 8'h0);
        chk("so_tx_hold", eng_tx, 8'hA5);
        tick();
        eng_done = 1'b1;
        eng_rx = 8'h3C;
        tick();
        chk("so_done_early", 8'(done), 8'h0);
        eng_done = 1'b0;
        tick();
        chk("so_done", 8'(done), 8'h1);
        chk("so_rx", rx, 8'h3C);
        chk("so_rdy", 8'(rdy), 8'h1);
        tick();
        chk("so_done_pulse", 8'(done), 8'h0);

        start = 2'b01;
        tx0 = 8'h5A;
        tick();
        chk("rb_start", 8'(eng_start), 8'h1);
        start = 2'b00;
        tick();
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        model_reset();
        chk("rb_gnt", 8'(gnt), 8'h0);
        chk("rb_nss", 8'(nss), 8'h3);
        chk("rb_rdy", 8'(rdy), 8'h0);
        chk("rb_done", 8'(done), 8'h0);
        chk("rb_rx", rx, 8'h00);
        chk("rb_tout", 8'(tout), 8'h0);
        chk("rb_eng_start", 8'(eng_start), 8'h0);
        chk("rb_eng_tx", eng_tx, 8'h00);
        tick();
        rst_n = 1'b1;
        eng_done = 1'b1;
        eng_rx = 8'hEE;
        tick();
        eng_done = 1'b0;
        tick();
        chk("rb_late_done", 8'(done), 8'h0);
        chk("rb_late_rx", rx, 8'h00);
        req = 2'b01;
        tick();
        tick();
        chk("rb_regrant", 8'(gnt), 8'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
